// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC xor speculative global history indexes a table of
// saturating counters; a sweep FSM initialises the table so it can live in RAM.
module gshare_predictor #(
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned GHR_W    = 8,
    parameter int unsigned INIT_CTR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    output logic             o_init_busy,
    input  logic             i_lu_valid,
    input  logic [IDX_W-1:0] i_lu_pc,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    output logic [IDX_W-1:0] o_pred_idx,
    output logic [GHR_W-1:0] o_pred_ghr,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic             i_upd_mispredict,
    input  logic [GHR_W-1:0] i_upd_ghr
);

    localparam int unsigned      DEPTH    = 2 ** IDX_W;
    localparam logic [0:0]       ST_INIT  = 1'b0;
    localparam logic [0:0]       ST_RUN   = 1'b1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [IDX_W-1:0] PTR_LAST = '1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [GHR_W-1:0] r_ghr;
    logic [CTR_W-1:0] r_table [DEPTH];

    logic             w_run;
    logic             w_active;
    logic             w_lu_fire;
    logic             w_upd_fire;
    logic             w_recover;
    logic [IDX_W-1:0] w_lu_idx;
    logic             w_lu_taken;
    logic [CTR_W-1:0] w_upd_old;
    logic [CTR_W-1:0] w_upd_new;
    logic [GHR_W:0]   w_ghr_spec;
    logic [GHR_W:0]   w_ghr_rec;

    assign w_run       = (r_state == ST_RUN);
    // A clear cycle drops both lookup and update.
    assign w_active    = w_run & ~i_clear;
    assign w_lu_fire   = w_active & i_lu_valid;
    assign w_upd_fire  = w_active & i_upd_valid;
    assign w_recover   = w_upd_fire & i_upd_mispredict;
    assign w_lu_idx    = i_lu_pc ^ IDX_W'(r_ghr);
    assign w_lu_taken  = r_table[w_lu_idx][CTR_W-1];
    assign w_upd_old   = r_table[i_upd_idx];
    assign w_ghr_spec  = {r_ghr, w_lu_taken};
    assign w_ghr_rec   = {i_upd_ghr, i_upd_taken};
    assign o_init_busy = ~w_run;

    always_comb begin
        w_upd_new = w_upd_old;
        if (i_upd_taken) begin
            if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + 1'b1;
        end else begin
            if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ghr   <= '0;
        end else if (!w_run) begin
            r_ptr <= r_ptr + 1'b1;
            r_ghr <= '0;
            if (r_ptr == PTR_LAST) r_state <= ST_RUN;
        end else if (i_clear) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ghr   <= '0;
        end else if (w_recover) begin
            r_ghr <= w_ghr_rec[GHR_W-1:0];
        end else if (w_lu_fire) begin
            r_ghr <= w_ghr_spec[GHR_W-1:0];
        end
    end

    // No reset on the table so it can map onto RAM; the sweep provides initial contents.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_table[r_ptr] <= CTR_INIT;
        end else if (w_upd_fire) begin
            r_table[i_upd_idx] <= w_upd_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pred_valid <= 1'b0;
            o_pred_taken <= 1'b0;
            o_pred_idx   <= '0;
            o_pred_ghr   <= '0;
        end else begin
            o_pred_valid <= w_lu_fire;
            if (w_lu_fire) begin
                o_pred_taken <= w_lu_taken;
                o_pred_idx   <= w_lu_idx;
                o_pred_ghr   <= r_ghr;
            end
        end
    end

endmodule
